ask_link_scheduler: RTL

ASK_LINK_SCHEDULER -- requirements
Module: ask_link_scheduler

---
 rtl/ask_link_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/ask_link_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ask_link_pkg.sv
// rtl/ask_link_pkg.sv - shared defaults and state encoding for the ASK link scheduler
package ask_link_pkg;

    localparam int DEF_N_REQ          = 4;
    localparam int DEF_WORD_W         = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_WAIT,
        ST_NEXT,
        ST_DELIVER
    } link_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requester at or after rr_ptr
module rr_arbiter
    import ask_link_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_REQ);

    logic [IDX_W:0] cand;

    // One extra bit on cand so the wrap works for any N_REQ, not only powers of two.
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= N_LIM) begin
                cand = cand - N_LIM;
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid                  = 1'b1;
                grant[cand[IDX_W-1:0]] = 1'b1;
                index                  = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ask_link_scheduler.sv
// rtl/ask_link_scheduler.sv - shares one ASK mod/demod pair among requesters, bit-serial LSB first
module ask_link_scheduler
    import ask_link_pkg::*;
#(
    parameter int N_REQ          = DEF_N_REQ,
    parameter int WORD_W         = DEF_WORD_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WORD_W-1:0]    word_in,
    output logic [N_REQ-1:0]           grant,
    output logic                       mod_start,
    output logic                       mod_bit,
    input  logic                       mod_done,
    output logic                       demod_start,
    input  logic                       demod_done,
    input  logic                       demod_bit,
    output logic [WORD_W-1:0]          rx_word,
    output logic [$clog2(N_REQ)-1:0]   rx_id,
    output logic                       rx_valid,
    output logic                       err_timeout,
    output logic                       busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    link_state_t state_q, state_d;

    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_index;
    logic              arb_valid;

    logic [IDX_W-1:0]  rr_ptr_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [IDX_W-1:0]  gnt_idx_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] rcv_q;
    logic [BIT_W-1:0]  bit_idx_q;
    logic              m_seen_q;
    logic              d_seen_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [WORD_W-1:0] rx_word_q;
    logic [IDX_W-1:0]  rx_id_q;

    logic              both_done;
    logic              tmo_hit;
    logic              last_bit;
    logic [IDX_W-1:0]  next_ptr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (arb_grant),
        .index  (arb_index),
        .valid  (arb_valid)
    );

    // The live done inputs count too, so the cycle the second done lands already moves on.
    assign both_done = (m_seen_q | mod_done) & (d_seen_q | demod_done);
    assign tmo_hit   = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign last_bit  = (bit_idx_q == BIT_W'(WORD_W - 1));
    assign next_ptr  = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_timeout = 1'b0;
        case (state_q)
            ST_IDLE:    if (|req) state_d = ST_ARB;
            ST_ARB:     state_d = arb_valid ? ST_START : ST_IDLE;
            ST_START:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (both_done) begin
                    state_d = ST_NEXT;
                end else if (tmo_hit) begin
                    err_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_NEXT:    state_d = last_bit ? ST_DELIVER : ST_START;
            ST_DELIVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            shift_q   <= '0;
            rcv_q     <= '0;
            bit_idx_q <= '0;
            m_seen_q  <= 1'b0;
            d_seen_q  <= 1'b0;
            tmo_cnt_q <= '0;
            rx_word_q <= '0;
            rx_id_q   <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (arb_valid) begin
                        gnt_q     <= arb_grant;
                        gnt_idx_q <= arb_index;
                        shift_q   <= word_in[arb_index*WORD_W +: WORD_W];
                        bit_idx_q <= '0;
                        rcv_q     <= '0;
                    end
                end
                ST_START: begin
                    m_seen_q  <= 1'b0;
                    d_seen_q  <= 1'b0;
                    tmo_cnt_q <= '0;
                end
                ST_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    if (mod_done) begin
                        m_seen_q <= 1'b1;
                    end
                    // Only the first demod_done of a bit is captured.
                    if (demod_done && !d_seen_q) begin
                        d_seen_q         <= 1'b1;
                        rcv_q[bit_idx_q] <= demod_bit;
                    end
                    if (err_timeout) begin
                        gnt_q    <= '0;
                        rr_ptr_q <= next_ptr;
                    end
                end
                ST_NEXT: begin
                    if (last_bit) begin
                        rx_word_q <= rcv_q;
                        rx_id_q   <= gnt_idx_q;
                    end else begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                        shift_q   <= shift_q >> 1;
                    end
                end
                ST_DELIVER: begin
                    gnt_q    <= '0;
                    rr_ptr_q <= next_ptr;
                end
                default: ;
            endcase
        end
    end

    assign grant       = gnt_q;
    assign mod_start   = (state_q == ST_START);
    assign demod_start = (state_q == ST_START);
    assign mod_bit     = shift_q[0] & (state_q inside {ST_START, ST_WAIT, ST_NEXT});
    assign rx_word     = rx_word_q;
    assign rx_id       = rx_id_q;
    assign rx_valid    = (state_q == ST_DELIVER);
    assign busy        = (state_q != ST_IDLE);

endmodule
